// File: rtl/mem_seq_ctrl.sv
// mem_seq_ctrl: sequences 32-bit CPU loads/stores onto a byte-wide memory
// with a registered read port. Requests are latched at the handshake. The
// controller then walks the byte lanes one per cycle in little-endian order,
// with addresses wrapping modulo 2**ADDRW. It returns one registered
// completion pulse.
//
// Optional feature: define MEM_SEQ_MISALIGN_TRAP_EN to reject misaligned
// half/word accesses with rsp_err instead of performing them byte-wise.
module mem_seq_ctrl #(
    parameter int ADDRW = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic             req_we,
    input  logic [1:0]       req_size,
    input  logic             req_unsigned,
    input  logic [31:0]      req_addr,
    input  logic [31:0]      req_wdata,
    output logic             rsp_valid,
    output logic [31:0]      rsp_rdata,
    output logic             rsp_err,
    output logic             mem_we,
    output logic [ADDRW-1:0] mem_waddr,
    output logic [7:0]       mem_wdata,
    output logic [ADDRW-1:0] mem_raddr,
    input  logic [7:0]       mem_rdata
);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        STORE  = 3'd1,
        LOAD   = 3'd2,
        LDWAIT = 3'd3,
        RESP   = 3'd4
    } state_e;

    // FSM and latched request context
    state_e           state_q, state_d;
    logic [1:0]       cnt_q, cnt_d;      // byte lane currently presented to memory
    logic [1:0]       last_q, last_d;    // index of the final byte lane (N-1)
    logic [1:0]       size_q, size_d;
    logic             uns_q, uns_d;
    logic [ADDRW-1:0] base_q, base_d;
    logic [31:0]      wbuf_q, wbuf_d;
    logic [31:0]      rbuf_q, rbuf_d;    // load bytes gathered so far

    // Registered outputs
    logic             mem_we_q, mem_we_d;
    logic [ADDRW-1:0] mem_waddr_q, mem_waddr_d;
    logic [7:0]       mem_wdata_q, mem_wdata_d;
    logic [ADDRW-1:0] mem_raddr_q, mem_raddr_d;
    logic             rsp_valid_q, rsp_valid_d;
    logic [31:0]      rsp_rdata_q, rsp_rdata_d;
    logic             rsp_err_q, rsp_err_d;

    logic             hs;
    logic             misalign;
    logic             reject;
    logic [ADDRW-1:0] req_addr_lo;
    logic [1:0]       req_last;
    logic [1:0]       cnt_inc;
    logic [1:0]       cnt_dec;
    logic [ADDRW-1:0] addr_inc;
    logic [31:0]      ld_word;

    // Upper address bits beyond the memory are intentionally ignored
    if (ADDRW < 32) begin : g_addr_hi
        logic unused_addr_hi;
        assign unused_addr_hi = ^req_addr[31:ADDRW];
    end

    assign req_ready   = (state_q == IDLE);
    assign hs          = req_valid && req_ready;
    assign req_addr_lo = req_addr[ADDRW-1:0];

`ifdef MEM_SEQ_MISALIGN_TRAP_EN
    assign misalign = ((req_size == 2'b01) && req_addr[0]) ||
                      ((req_size == 2'b10) && (req_addr[1:0] != 2'b00));
`else
    assign misalign = 1'b0;
`endif

    assign reject   = (req_size == 2'b11) || misalign;
    assign req_last = (req_size == 2'b00) ? 2'd0 :
                      (req_size == 2'b01) ? 2'd1 : 2'd3;
    assign cnt_inc  = cnt_q + 2'd1;
    assign cnt_dec  = cnt_q - 2'd1;
    assign addr_inc = base_q + ADDRW'(cnt_inc);

    // Sign/zero extension of a completed load according to its size
    function automatic logic [31:0] extend_load(input logic [31:0] w,
                                                input logic [1:0]  sz,
                                                input logic        u);
        logic [31:0] r;
        case (sz)
            2'b00:   r = u ? {24'b0, w[7:0]}  : {{24{w[7]}}, w[7:0]};
            2'b01:   r = u ? {16'b0, w[15:0]} : {{16{w[15]}}, w[15:0]};
            default: r = w;
        endcase
        return r;
    endfunction

    // Final load word: gathered lanes plus the last byte arriving this cycle
    always_comb begin
        ld_word = rbuf_q;
        ld_word[{last_q, 3'b000} +: 8] = mem_rdata;
    end

    // State and request-context registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            last_q  <= '0;
            size_q  <= '0;
            uns_q   <= 1'b0;
            base_q  <= '0;
            wbuf_q  <= '0;
            rbuf_q  <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            last_q  <= last_d;
            size_q  <= size_d;
            uns_q   <= uns_d;
            base_q  <= base_d;
            wbuf_q  <= wbuf_d;
            rbuf_q  <= rbuf_d;
        end
    end

    // Next-state decode
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE: begin
                if (hs) begin
                    if (reject)      state_d = RESP;
                    else if (req_we) state_d = STORE;
                    else             state_d = LOAD;
                end
            end
            STORE:   if (cnt_q == last_q) state_d = RESP;
            LOAD:    if (cnt_q == last_q) state_d = LDWAIT;
            LDWAIT:  state_d = RESP;
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Next values of the datapath and output registers. Outputs are computed
    // one cycle early so that every port except req_ready comes from a flop.
    always_comb begin
        cnt_d       = cnt_q;
        last_d      = last_q;
        size_d      = size_q;
        uns_d       = uns_q;
        base_d      = base_q;
        wbuf_d      = wbuf_q;
        rbuf_d      = rbuf_q;
        mem_we_d    = 1'b0;
        mem_waddr_d = mem_waddr_q;
        mem_wdata_d = mem_wdata_q;
        mem_raddr_d = mem_raddr_q;
        rsp_valid_d = 1'b0;
        rsp_rdata_d = '0;
        rsp_err_d   = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (hs) begin
                    cnt_d  = '0;
                    last_d = req_last;
                    size_d = req_size;
                    uns_d  = req_unsigned;
                    base_d = req_addr_lo;
                    wbuf_d = req_wdata;
                    rbuf_d = '0;
                    if (reject) begin
                        rsp_valid_d = 1'b1;
                        rsp_err_d   = 1'b1;
                    end else if (req_we) begin
                        mem_we_d    = 1'b1;
                        mem_waddr_d = req_addr_lo;
                        mem_wdata_d = req_wdata[7:0];
                    end else begin
                        mem_raddr_d = req_addr_lo;
                    end
                end
            end
            STORE: begin
                if (cnt_q == last_q) begin
                    rsp_valid_d = 1'b1;
                end else begin
                    cnt_d       = cnt_inc;
                    mem_we_d    = 1'b1;
                    mem_waddr_d = addr_inc;
                    mem_wdata_d = wbuf_q[{cnt_inc, 3'b000} +: 8];
                end
            end
            LOAD: begin
                // Read data lags the address by one cycle, so lane cnt-1 lands now
                if (cnt_q != 2'd0) begin
                    rbuf_d[{cnt_dec, 3'b000} +: 8] = mem_rdata;
                end
                if (cnt_q != last_q) begin
                    cnt_d       = cnt_inc;
                    mem_raddr_d = addr_inc;
                end
            end
            LDWAIT: begin
                rsp_valid_d = 1'b1;
                rsp_rdata_d = extend_load(ld_word, size_q, uns_q);
            end
            RESP: begin
            end
            default: begin
            end
        endcase
    end

    // Output registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mem_we_q    <= 1'b0;
            mem_waddr_q <= '0;
            mem_wdata_q <= '0;
            mem_raddr_q <= '0;
            rsp_valid_q <= 1'b0;
            rsp_rdata_q <= '0;
            rsp_err_q   <= 1'b0;
        end else begin
            mem_we_q    <= mem_we_d;
            mem_waddr_q <= mem_waddr_d;
            mem_wdata_q <= mem_wdata_d;
            mem_raddr_q <= mem_raddr_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_rdata_q <= rsp_rdata_d;
            rsp_err_q   <= rsp_err_d;
        end
    end

    assign mem_we    = mem_we_q;
    assign mem_waddr = mem_waddr_q;
    assign mem_wdata = mem_wdata_q;
    assign mem_raddr = mem_raddr_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_rdata = rsp_rdata_q;
    assign rsp_err   = rsp_err_q;

endmodule

// File: doc/mem_seq_ctrl.md
MEM_SEQ_CTRL -- requirements
Module: mem_seq_ctrl

Interface
REQ-001 Parameter ADDRW, default 8; byte-address width of the attached byte-wide data memory (DEPTH = 2**ADDRW bytes).
REQ-002 clk  input  1  single clock; all state updates on posedge clk.
REQ-003 rst_n  input  1  reset, asynchronous, active-low.
REQ-004 req_valid  input  1  CPU load/store request present.
REQ-005 req_ready  output  1  controller can accept a request (high only in IDLE).
REQ-006 req_we  input  1  1 = store, 0 = load.
REQ-007 req_size  input  2  00 byte, 01 half, 10 word, 11 reserved.
REQ-008 req_unsigned  input  1  load zero-extends when 1, sign-extends when 0.
REQ-009 req_addr  input  32  byte address; only bits [ADDRW-1:0] are used.
REQ-010 req_wdata  input  32  store data, little-endian byte order.
REQ-011 rsp_valid  output  1  one-cycle completion pulse.
REQ-012 rsp_rdata  output  32  extended load data, valid with rsp_valid; 0 for stores and errors.
REQ-013 rsp_err  output  1  request rejected, valid with rsp_valid.
REQ-014 mem_we, mem_waddr[ADDRW-1:0], mem_wdata[7:0]  outputs  memory write port.
REQ-015 mem_raddr[ADDRW-1:0]  output; mem_rdata[7:0]  input  memory read port; mem_rdata is valid one cycle after mem_raddr is presented (registered read).

Function
REQ-016 The FSM SHALL have states IDLE, STORE, LOAD, LDWAIT and RESP; handshake occurs on a clock edge where req_valid && req_ready.
REQ-017 Byte count N SHALL be 1/2/4 for size 00/01/10; the request SHALL be latched at the handshake edge, and later input changes are ignored.
REQ-018 STORE: for k = 0..N-1, in cycle k+1 after the handshake, mem_we=1, mem_waddr=addr+k, mem_wdata=wdata[8k+7:8k]; RESP follows, so rsp_valid is high in cycle N+1.
REQ-019 LOAD: mem_raddr=addr+k in cycle k+1; byte k SHALL be captured in cycle k+2 into rdata[8k+7:8k]; LDWAIT captures the last byte; rsp_valid is high in cycle N+2.
REQ-020 Addresses SHALL wrap modulo 2**ADDRW (addr 0xFF, word access with ADDRW=8 touches 0xFF, 0x00, 0x01, 0x02).
REQ-021 Load extension: byte/half results SHALL be sign- or zero-extended from bit 7/15 per req_unsigned; word results are unmodified.
REQ-022 req_size=11 SHALL produce no memory access, with rsp_valid=1, rsp_err=1 and rsp_rdata=0 in cycle 1.
REQ-023 mem_we SHALL be 0 in every state except STORE; rsp_valid SHALL be high only in RESP, for exactly one cycle, with no backpressure.
REQ-024 RESP SHALL return to IDLE; req_ready SHALL be 1 in the cycle after rsp_valid, giving back-to-back throughput of one request per N+2 (store) or N+3 (load) cycles.
REQ-025 All outputs SHALL be driven from registers, except req_ready, which is decoded from state.

Reset
REQ-026 rst_n low SHALL immediately force IDLE, with req_ready=1 and mem_we=0; rsp_valid, rsp_rdata, rsp_err, all mem addresses and mem_wdata SHALL be forced to 0.
REQ-027 A reset asserted mid-operation SHALL abort the request with no response; bytes already written are not rolled back.

Configuration
REQ-028 Macro MEM_SEQ_MISALIGN_TRAP_EN: when defined, a half access with addr[0]=1 or a word access with addr[1:0]!=0 SHALL be rejected as in REQ-022 (rsp_err=1, no memory access).
REQ-029 Without MEM_SEQ_MISALIGN_TRAP_EN, misaligned accesses SHALL proceed byte-wise per REQ-018/019 and rsp_err is set only for size 11.

Verification
REQ-030 Store word 0xDEADBEEF @0x10 -> mem_we for 4 cycles with (0x10,EF),(0x11,BE),(0x12,AD),(0x13,DE); rsp_valid in cycle 5.
REQ-031 Load byte @0x11 holding 0xBE, signed -> rsp_rdata=0xFFFFFFBE in cycle 3; the same load unsigned -> 0x000000BE.
REQ-032 Load word @0xFF (ADDRW=8), bytes 0x11,0x22,0x33,0x44 at 0xFF,0x00,0x01,0x02 -> rsp_rdata=0x44332211 in cycle 6.
REQ-033 Half store @0x21 -> with macro: rsp_err=1 in cycle 1 and mem_we never set; without macro: writes 0x21, 0x22 and rsp_err=0.
REQ-034 req_size=11 -> rsp_err=1 in cycle 1; then rst_n pulsed low during the 2nd byte of a word store -> mem_we drops immediately, no rsp_valid, and req_ready=1 after release.
